mem_arbiter: RTL
================

Name: mem_arbiter

Overview:
- Shares one external memory port between the core's instruction-cache refill port and its data-memory port.
- Sits between the single-cycle datapath (i_cache refill side, d_mem side) and the system bus/memory.
- Serialises requests, keeps arbitration fair and latches the request fields at grant.
- Adds a per-transaction timeout, so a dead slave produces an error response instead of a hung core.

Parameters:
- XLEN, 32, data/address width.
- DM_PRIORITY, 1: 1 = data port wins simultaneous requests; 0 = round-robin on last grant.
- TIMEOUT, 255: cycles to wait for i_mem_ack before an error completion; 0 disables the timeout.

Ports:
- i_clk  in  1  clock
- i_rst  in  1  synchronous reset, active-low
- i_ic_req  in  1  instruction refill request (level; held until o_ic_ready)
- i_ic_addr  in  XLEN  refill word address
- o_ic_ready  out  1  one-cycle completion pulse to the I-side
- o_ic_data  out  XLEN  refill data, valid with o_ic_ready
- o_ic_err  out  1  timeout error, valid with o_ic_ready
- i_dm_req  in  1  data request (level; held until o_dm_ready)
- i_dm_we  in  1  1 = write, 0 = read
- i_dm_addr  in  XLEN  data address
- i_dm_wdata  in  XLEN  write data
- i_dm_be  in  XLEN/8  byte enables
- o_dm_ready  out  1  one-cycle completion pulse to the D-side
- o_dm_rdata  out  XLEN  read data, valid with o_dm_ready
- o_dm_err  out  1  timeout error, valid with o_dm_ready
- o_mem_req  out  1  memory request, held until ack or timeout
- o_mem_we  out  1  write strobe
- o_mem_addr  out  XLEN  address
- o_mem_wdata  out  XLEN  write data
- o_mem_be  out  XLEN/8  byte enables (all ones for I-side)
- i_mem_rdata  in  XLEN  read data, valid with i_mem_ack
- i_mem_ack  in  1  slave completion

Behaviour:
- Reset (i_rst=0 at a posedge):
  - state IDLE; all outputs 0; timeout counter 0.
  - last_grant = IC, so the first round-robin tie goes to DM.
  - A reset mid-transaction drops o_mem_req on the next edge; the slave treats this as an abort.
- FSM states: IDLE, BUSY_IC, BUSY_DM, RESP.
- IDLE:
  - Only i_ic_req set -> BUSY_IC. Only i_dm_req set -> BUSY_DM.
  - Both set -> winner per DM_PRIORITY / last_grant.
  - At the grant edge, latch addr/we/wdata/be into the o_mem_* registers and set o_mem_req=1.
  - The I-side always uses we=0 and be all ones.
- BUSY_x:
  - o_mem_* held stable.
  - Counter increments each cycle.
  - i_mem_ack=1 -> capture i_mem_rdata into o_x_data/o_x_rdata, pulse o_x_ready=1 and err=0 next cycle, o_mem_req=0, go to RESP.
  - TIMEOUT!=0 and counter==TIMEOUT-1 with no ack -> same transition with o_x_err=1 and data=0.
  - Ack wins if it arrives on the timeout cycle.
- RESP:
  - Lasts exactly one cycle; the ready/err pulse is visible here, then IDLE.
  - Requests are ignored in RESP, so a requester still holding req on its ready cycle is never double-served.
  - last_grant is updated on entry to RESP.
- Latency: req seen in IDLE at edge 0 -> o_mem_req high after edge 0. Ack sampled at edge N -> ready high after edge N. Minimum turnaround is 3 cycles per transaction.
- Request changes: changes to a requester's address/data while its request is in BUSY are ignored (latched values are used). A request dropped before ready still completes the memory access; the ready pulse is issued regardless.
- i_mem_ack outside BUSY is ignored.
- Counter width: $clog2(TIMEOUT+1). It clears on every grant.
- Outputs are registered; no combinational path from i_mem_* to o_ic_*/o_dm_*.

Decomposition:
- arvi_mem_pkg:
  - typedef enum logic [1:0] {IDLE, BUSY_IC, BUSY_DM, RESP} arb_state_t
  - typedef enum logic {GNT_IC, GNT_DM} grant_t
- One sub-module, arb_timeout_cnt: counter with clear, enable and expiry output, parameterised by TIMEOUT.

Test Plan:
- Single I read: i_ic_req with addr 0x100, ack 2 cycles after o_mem_req with rdata 0xDEADBEEF -> o_mem_addr=0x100, we=0, be=0xF; o_ic_ready pulse with data 0xDEADBEEF; err=0.
- Simultaneous requests, DM_PRIORITY=1: IC 0x200 read and DM write 0x300/0x12345678/be=0x3, both held -> DM granted first with wdata/be exact; IC served after RESP; never concurrent.
- Round-robin, DM_PRIORITY=0: both requests held continuously for 4 transactions -> grants alternate DM, IC, DM, IC.
- Timeout, TIMEOUT=8: DM read, ack never asserted -> o_mem_req high exactly 8 cycles, then o_dm_ready=1, o_dm_err=1, rdata=0; ack on cycle 8 instead -> err=0.
- Reset mid-op: i_rst=0 while in BUSY_IC -> next cycle o_mem_req=0, no ready pulse; after release, a fresh request completes normally.
- Held request: requester keeps i_ic_req=1 through the RESP cycle -> exactly one memory transaction per request; second access only if req remains set after RESP.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared types for the instruction/data memory-port arbiter.
// Covers the FSM state, the grant owner and the timeout counter width.
package arvi_mem_pkg;

    typedef enum logic [1:0] {IDLE, BUSY_IC, BUSY_DM, RESP} arb_state_t;

    typedef enum logic {GNT_IC, GNT_DM} grant_t;

    // A disabled timeout (0) still gets a 1-bit counter so no zero-width vector appears.
    function automatic int cnt_width(input int timeout);
        return (timeout > 0) ? $clog2(timeout + 1) : 1;
    endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of the I-refill, D-memory and external memory ports of the arbiter.
// slave is the arbiter's view; master is the view of the core and memory around it.
interface mem_arbiter_if #(
    parameter int XLEN = 32
);
    logic              i_ic_req;
    logic [XLEN-1:0]   i_ic_addr;
    logic              o_ic_ready;
    logic [XLEN-1:0]   o_ic_data;
    logic              o_ic_err;

    logic              i_dm_req;
    logic              i_dm_we;
    logic [XLEN-1:0]   i_dm_addr;
    logic [XLEN-1:0]   i_dm_wdata;
    logic [XLEN/8-1:0] i_dm_be;
    logic              o_dm_ready;
    logic [XLEN-1:0]   o_dm_rdata;
    logic              o_dm_err;

    logic              o_mem_req;
    logic              o_mem_we;
    logic [XLEN-1:0]   o_mem_addr;
    logic [XLEN-1:0]   o_mem_wdata;
    logic [XLEN/8-1:0] o_mem_be;
    logic [XLEN-1:0]   i_mem_rdata;
    logic              i_mem_ack;

    modport slave (
        input  i_ic_req, i_ic_addr,
        output o_ic_ready, o_ic_data, o_ic_err,
        input  i_dm_req, i_dm_we, i_dm_addr, i_dm_wdata, i_dm_be,
        output o_dm_ready, o_dm_rdata, o_dm_err,
        output o_mem_req, o_mem_we, o_mem_addr, o_mem_wdata, o_mem_be,
        input  i_mem_rdata, i_mem_ack
    );

    modport master (
        output i_ic_req, i_ic_addr,
        input  o_ic_ready, o_ic_data, o_ic_err,
        output i_dm_req, i_dm_we, i_dm_addr, i_dm_wdata, i_dm_be,
        input  o_dm_ready, o_dm_rdata, o_dm_err,
        input  o_mem_req, o_mem_we, o_mem_addr, o_mem_wdata, o_mem_be,
        output i_mem_rdata, i_mem_ack
    );

endinterface

// File: rtl/mem_arbiter_arb_timeout_cnt.sv
// Per-transaction wait counter; expired is high on the last allowed cycle.
// TIMEOUT of 0 disables expiry entirely.
module arb_timeout_cnt
    import arvi_mem_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int W = cnt_width(TIMEOUT);
    localparam logic [W-1:0] LAST = (TIMEOUT > 0) ? W'(TIMEOUT - 1) : '0;

    logic [W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + W'(1);
        end
    end

    assign expired = (TIMEOUT > 0) && (cnt == LAST);

endmodule

// File: rtl/mem_arbiter.sv
// Shares one memory port between the I-cache refill and D-memory ports.
// One transaction at a time, fields latched at grant, timeout turns a dead slave into an error.
module mem_arbiter
    import arvi_mem_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int DM_PRIORITY = 1,
    parameter int TIMEOUT     = 255
) (
    input  logic          i_clk,
    input  logic          i_rst,
    mem_arbiter_if.slave  bus
);

    arb_state_t state;
    grant_t     last_grant;
    logic       busy;
    logic       expired;
    logic       dm_wins;
    logic       done;

    assign busy = (state == BUSY_IC) || (state == BUSY_DM);
    assign done = bus.i_mem_ack || expired;

    // On a tie the data port wins outright, or whenever the I-side had the last turn.
    assign dm_wins = bus.i_dm_req &&
                     (!bus.i_ic_req || (DM_PRIORITY != 0) || (last_grant == GNT_IC));

    arb_timeout_cnt #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk     (i_clk),
        .rst_n   (i_rst),
        .clr     (!busy),
        .en      (busy),
        .expired (expired)
    );

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            state           <= IDLE;
            last_grant      <= GNT_IC;
            bus.o_ic_ready  <= 1'b0;
            bus.o_ic_data   <= '0;
            bus.o_ic_err    <= 1'b0;
            bus.o_dm_ready  <= 1'b0;
            bus.o_dm_rdata  <= '0;
            bus.o_dm_err    <= 1'b0;
            bus.o_mem_req   <= 1'b0;
            bus.o_mem_we    <= 1'b0;
            bus.o_mem_addr  <= '0;
            bus.o_mem_wdata <= '0;
            bus.o_mem_be    <= '0;
        end else begin
            bus.o_ic_ready <= 1'b0;
            bus.o_ic_err   <= 1'b0;
            bus.o_dm_ready <= 1'b0;
            bus.o_dm_err   <= 1'b0;
            case (state)
                IDLE: begin
                    if (dm_wins) begin
                        state           <= BUSY_DM;
                        bus.o_mem_req   <= 1'b1;
                        bus.o_mem_we    <= bus.i_dm_we;
                        bus.o_mem_addr  <= bus.i_dm_addr;
                        bus.o_mem_wdata <= bus.i_dm_wdata;
                        bus.o_mem_be    <= bus.i_dm_be;
                    end else if (bus.i_ic_req) begin
                        state           <= BUSY_IC;
                        bus.o_mem_req   <= 1'b1;
                        bus.o_mem_we    <= 1'b0;
                        bus.o_mem_addr  <= bus.i_ic_addr;
                        bus.o_mem_wdata <= '0;
                        bus.o_mem_be    <= '1;
                    end
                end
                BUSY_IC: begin
                    // An ack on the expiry cycle still counts as a good completion.
                    if (done) begin
                        state          <= RESP;
                        last_grant     <= GNT_IC;
                        bus.o_mem_req  <= 1'b0;
                        bus.o_ic_ready <= 1'b1;
                        bus.o_ic_err   <= !bus.i_mem_ack;
                        bus.o_ic_data  <= bus.i_mem_ack ? bus.i_mem_rdata : '0;
                    end
                end
                BUSY_DM: begin
                    if (done) begin
                        state          <= RESP;
                        last_grant     <= GNT_DM;
                        bus.o_mem_req  <= 1'b0;
                        bus.o_dm_ready <= 1'b1;
                        bus.o_dm_err   <= !bus.i_mem_ack;
                        bus.o_dm_rdata <= bus.i_mem_ack ? bus.i_mem_rdata : '0;
                    end
                end
                RESP: begin
                    // Requests are not looked at here, so a still-held request is not served twice.
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
